// File: rtl/mac_accum.sv
// Multiply-accumulate over groups of N unsigned 4x4 products.
// Each completed 12-bit sum is held until downstream takes it.

module mul4x4_wallace (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;

  // Two 3:2 carry-save levels, then a single carry-propagate add.
  // Carries out of bit 7 can be dropped because the product is below 256.
  always_comb begin
    r0 = {4'b0000, a & {4{b[0]}}};
    r1 = {3'b000, a & {4{b[1]}}, 1'b0};
    r2 = {2'b00, a & {4{b[2]}}, 2'b00};
    r3 = {1'b0, a & {4{b[3]}}, 3'b000};
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
    p  = s2 + c2;
  end
endmodule

module mac_accum #(
  parameter int unsigned N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  typedef enum logic {ACC, DONE} state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [11:0] acc;
  logic [7:0]  product;
  logic [11:0] sum;
  logic        accept;

  mul4x4_wallace u_mul (
    .a (a),
    .b (b),
    .p (product)
  );

  assign sum = acc + {4'b0000, product};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = ACC;
    end else begin
      case (state)
        ACC:     if (accept && cnt == LAST) next_state = DONE;
        DONE:    if (out_ready) next_state = ACC;
        default: next_state = ACC;
      endcase
    end
  end

  // out_valid is exactly "holding a result", so it is decoded from state.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state == ACC) && (cnt != 4'd0);
    accept    = in_valid && (state == ACC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (cnt == LAST) begin
        out_data <= sum;
        acc      <= '0;
        cnt      <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter N, default 4, meaning products summed per result; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port clr  input  1  synchronous abort of the accumulation in progress.
REQ-005 SHALL have port a  input  4  unsigned multiplicand.
REQ-006 SHALL have port b  input  4  unsigned multiplier.
REQ-007 SHALL have port in_valid  input  1  a/b pair presented.
REQ-008 SHALL have port in_ready  output  1  block accepts the a/b pair this cycle.
REQ-009 SHALL have port out_data  output  12  accumulated sum of N products.
REQ-010 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-012 SHALL have port busy  output  1  high when 1..N-1 products are accumulated.

Function
REQ-013 SHALL compute each product as unsigned 4x4 -> 8-bit, a*b (range 0..225), through the team's 4x4 Wallace multiplier, combinationally, in the accept cycle.
REQ-014 SHALL implement two states, ACC and DONE; reset state is ACC.
REQ-015 SHALL drive in_ready = 1 in ACC and 0 in DONE, with no combinational path from out_ready.
REQ-016 SHALL accept a pair only on a cycle where in_valid && in_ready; in_valid without in_ready has no effect.
REQ-017 On accept in ACC with cnt < N-1, SHALL do acc <= acc + product, cnt <= cnt + 1, and stay in ACC.
REQ-018 On accept in ACC with cnt == N-1, SHALL do out_data <= acc + product, out_valid <= 1, acc <= 0, cnt <= 0, and go to DONE.
REQ-019 Result latency SHALL be 1 cycle: out_valid is high on the clock edge after the Nth accept.
REQ-020 Width SHALL be 12 bits for acc and out_data; max sum 225*16 = 3600 < 4096, so no overflow or saturation logic is needed.
REQ-021 In DONE, out_data and out_valid SHALL hold stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready in DONE, SHALL clear out_valid and return to ACC on the next edge; out_data keeps its last value.
REQ-023 In DONE with in_valid and out_ready both high, SHALL perform the handoff only; the pair is accepted earliest on the following cycle.
REQ-024 With N == 1, every accept SHALL go directly ACC -> DONE, and out_data equals that single product.
REQ-025 clr SHALL have priority over the REQ-017..REQ-022 updates, below rst_n.
REQ-026 When clr is high, SHALL set acc = 0, cnt = 0, out_valid = 0, state ACC; any pending result is discarded, and any pair presented that cycle is not counted.
REQ-027 busy SHALL be (state == ACC) && (cnt != 0).
REQ-028 cnt SHALL never exceed N-1; there is no wrap beyond N.

Reset
REQ-029 With rst_n low at a rising edge, SHALL set state ACC, acc 0, cnt 0, out_data 0x000, out_valid 0.
REQ-030 During reset, in_ready SHALL read 1 and busy SHALL read 0.
REQ-031 Reset mid-accumulation or in DONE SHALL discard all partial and pending data; the first accept after release starts a fresh group.
REQ-032 Outputs SHALL be defined (no X) from the first edge with rst_n low.

Verification
REQ-033 N=4, pairs (3,5),(2,7),(0,9),(1,1) back-to-back, out_ready=1 -> out_data=0x01E (30), out_valid for exactly 1 cycle, one cycle after the 4th accept.
REQ-034 N=4, four pairs (15,15) -> out_data=0x384 (900); with N=16, sixteen (15,15) pairs -> 0xE10 (3600), no overflow.
REQ-035 Backpressure: result 30 ready, out_ready=0 for 3 cycles, in_valid=1 throughout -> out_data holds 30, in_ready=0, no pairs accepted; raise out_ready -> handoff, then the next group starts the following cycle.
REQ-036 rst_n low for 1 cycle after 2 of 4 pairs -> acc cleared; next 4 pairs (1,1) -> out_data=4.
REQ-037 clr asserted on the same cycle as the 3rd pair -> that pair is ignored, busy=0; the following 4 pairs (2,2) -> out_data=16.
REQ-038 N=1, pair (15,1) -> out_data=15 on the next cycle, in_ready=0 until out_ready is seen.
